frac_disp_scan: RTL

Display stage directly downstream of the fraction-reduction block. Captures the reduced numerator/denominator pair (each 0..31, 5 bits) on a load strobe and converts both to two BCD digits with a sequential subtract-10 loop. It then drives a 4-digit, common-anode, time-multiplexed 7-segment display as "NN.DD", with the decimal point separating numerator from denominator.

---
 rtl/frac_disp_scan.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frac_disp_scan.sv
// frac_disp_scan: captures a reduced fraction (num/den, 0..31 each), converts
// both values to two BCD digits by repeated subtract-10, and scans them onto a
// 4-digit common-anode 7-segment display as "NN.DD".
// Optional macro FRAC_LZB_EN: blank tens digits that are zero (dp stays lit).
module frac_disp_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] num_i,
    input  logic [4:0] den_i,
    output logic       ready_o,
    output logic       done_o,
    output logic [7:0] seg_o,
    output logic [3:0] an_o
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {BLANK, CONV, SHOW} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [4:0]    nrem, drem;
    logic [1:0]    nten, dten;
    logic [1:0]    d_nt, d_dt;
    logic [3:0]    d_no, d_do;
    logic          shown;
    logic          nge, dge;
    logic [3:0]    dig;
    logic          is_tens, dp_on;
    logic [6:0]    pat;
    logic [7:0]    seg_nx;
    logic [3:0]    an_nx;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= BLANK;
        else     state <= state_nx;
    end

    // Next-state, ready and done; a load in the final CONV cycle restarts
    // conversion instead of committing the stale digits
    always_comb begin
        state_nx = state;
        done_o   = 1'b0;
        ready_o  = (state != CONV);
        nge      = (nrem >= 5'd10);
        dge      = (drem >= 5'd10);
        if (load) begin
            state_nx = CONV;
        end else if (state == CONV && !nge && !dge) begin
            state_nx = SHOW;
            done_o   = !rst;
        end
    end

    // Working remainders, tens counters and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            nrem  <= '0;
            drem  <= '0;
            nten  <= '0;
            dten  <= '0;
            d_nt  <= '0;
            d_dt  <= '0;
            d_no  <= '0;
            d_do  <= '0;
            shown <= 1'b0;
        end else if (load) begin
            nrem <= num_i;
            drem <= den_i;
            nten <= '0;
            dten <= '0;
        end else if (state == CONV) begin
            if (nge) begin
                nrem <= nrem - 5'd10;
                nten <= nten + 2'd1;
            end
            if (dge) begin
                drem <= drem - 5'd10;
                dten <= dten + 2'd1;
            end
            if (done_o) begin
                d_nt  <= nten;
                d_no  <= nrem[3:0];
                d_dt  <= dten;
                d_do  <= drem[3:0];
                shown <= 1'b1;
            end
        end
    end

    // Free-running scan prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Digit selection and segment pattern for the current index
    always_comb begin
        dig     = d_do;
        is_tens = 1'b0;
        dp_on   = 1'b0;
        case (idx)
            2'd0: dig = d_do;
            2'd1: begin dig = {2'b00, d_dt}; is_tens = 1'b1; end
            2'd2: begin dig = d_no; dp_on = 1'b1; end
            default: begin dig = {2'b00, d_nt}; is_tens = 1'b1; end
        endcase
        pat = seg_decode(dig);
`ifdef FRAC_LZB_EN
        if (is_tens && dig == 4'd0) pat = 7'h7F;
`else
        if (is_tens && dig > 4'd9) pat = 7'h7F;
`endif
        seg_nx = {~dp_on, pat};
        an_nx  = ~(4'b0001 << idx);
        if (!shown) begin
            seg_nx = 8'hFF;
            an_nx  = 4'hF;
        end
    end

    // Registered display drive
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o <= 8'hFF;
            an_o  <= 4'hF;
        end else begin
            seg_o <= seg_nx;
            an_o  <= an_nx;
        end
    end

endmodule
